r_i_trace_buf: RTL

Commit-trace capture buffer on the result side of the R_I_CPU. The testbench and stepping logic drive the CPU. This block consumes what the CPU produces.
- On every instruction commit it records the result word `douta` and the flags `zfa` and `ofa` into an on-chip buffer.
- Recording starts after a programmable trigger.
- A host or bench drains the buffer through a one-word-per-request read port.

---
 rtl/r_i_trace_buf.sv | 128 ++++++++++++
 1 files changed

// File: rtl/r_i_trace_buf.sv
// Commit-trace capture buffer: records {ofa, zfa, douta} on CPU commits after a trigger; 1-cycle read latency.
// TRACE_STOP_ON_FULL_EN: stop capture when full (drop further commits) instead of overwriting as a ring.
module r_i_trace_buf #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clka,
   input  logic          rsta,
   input  logic          commit,
   input  logic [31:0]   douta,
   input  logic          zfa,
   input  logic          ofa,
   input  logic          arm,
   input  logic [31:0]   trig_val,
   input  logic          rd_req,
   output logic          rd_valid,
   output logic [33:0]   rd_data,
   output logic [AW:0]   count,
   output logic          empty,
   output logic          full,
   output logic          overflow,
   output logic [1:0]    state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } st_t;

   typedef struct packed {
      logic        ofa;
      logic        zfa;
      logic [31:0] dat;
   } entry_t;

   st_t           st;
   entry_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          wr_req;
   logic          wr_acc;
   logic          rd_ok;
   logic          drop;
   logic          ovr;
   logic          cnt_inc;
   logic          cnt_dec;
   entry_t        wr_entry;

   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));
   assign state = st;

   // The triggering commit in ARMED is itself the first captured entry.
   assign wr_req   = commit && ((st == CAPTURE) || ((st == ARMED) && (douta == trig_val)));
   assign rd_ok    = rd_req && !empty;
   assign wr_entry = '{ofa: ofa, zfa: zfa, dat: douta};

`ifdef TRACE_STOP_ON_FULL_EN
   assign wr_acc = wr_req && !full;
   assign drop   = wr_req && full;
   assign ovr    = 1'b0;
`else
   // Ring mode: a write into a full buffer with no concurrent read evicts the oldest entry.
   assign wr_acc = wr_req;
   assign drop   = 1'b0;
   assign ovr    = wr_req && full && !rd_ok;
`endif

   assign cnt_inc = wr_acc && !rd_ok && !full;
   assign cnt_dec = rd_ok && !wr_acc;

   always_ff @(posedge clka) begin
      if (wr_acc) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         st       <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_ok;
         if (rd_ok) begin
            rd_data <= mem[rd_ptr];
         end
         if (wr_acc) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_ok || ovr) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (cnt_inc) begin
            count <= count + (AW+1)'(1);
         end else if (cnt_dec) begin
            count <= count - (AW+1)'(1);
         end
         if (drop || ovr) begin
            overflow <= 1'b1;
         end
         case (st)
            IDLE: begin
               if (arm) st <= ARMED;
            end
            ARMED: begin
               if (wr_req) st <= CAPTURE;
            end
            CAPTURE: begin
`ifdef TRACE_STOP_ON_FULL_EN
               if (wr_acc && !rd_ok && (count == (AW+1)'(DEPTH - 1))) st <= DONE;
`endif
            end
            DONE: begin
               if (arm) st <= ARMED;
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule
